scan_decoder: RTL and testbench
===============================

Name: scan_decoder

Overview:
- Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder.
- Successor to the team's fixed 3-to-8 gate-level decoder.
- Two modes:
  - direct mode: decodes a selector accepted over a valid/ready handshake.
  - scan mode: steps automatically through all outputs at a programmable rate.
- Sits between control logic and multiplexed outputs such as LED/7-segment digit selects and row strobes.

Parameters:
- SEL_W, 3, selector width; output width is OUT_W = 2**SEL_W (localparam); legal range 1..6.
- SCAN_DIV, 4, clock cycles each output stays active in scan mode; must be >= 1.
- ACTIVE_LOW, 0, when 1 all D bits are inverted at the output register, so the active bit is 0 and inactive bits are 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active low.
- en  in  1  global enable.
- mode  in  1  0 = direct, 1 = scan.
- sel_valid  in  1  selector offered.
- sel  in  SEL_W  selector value.
- sel_ready  out  1  selector accepted when high together with sel_valid.
- D  out  OUT_W  registered one-hot decode, polarity set by ACTIVE_LOW.
- cur_idx  out  SEL_W  index currently driven on D.
- wrap  out  1  one-cycle pulse when scan wraps from OUT_W-1 to 0.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state = IDLE, cur_idx = 0, prescaler = 0, wrap = 0.
  - D = all inactive (0s, or 1s when ACTIVE_LOW).
  - Reset mid-scan or mid-handshake discards all progress; nothing resumes.
- FSM states: IDLE, DIRECT, SCAN. Registered; transitions are evaluated each cycle.
  - en = 0 from any state: go to IDLE.
  - IDLE with en = 1: go to DIRECT if mode = 0, SCAN if mode = 1.
  - DIRECT with en = 1 and mode = 1: go to SCAN.
  - SCAN with en = 1 and mode = 0: go to DIRECT.
- sel_ready = en && state == DIRECT. It is combinational from registered state, so there is no dependency on sel_valid.
- DIRECT:
  - On a handshake (sel_valid && sel_ready), cur_idx <= sel and D <= onehot(sel) at the same edge, giving 1-cycle latency.
  - Without a handshake, D and cur_idx hold.
  - Back-to-back handshakes are accepted every cycle.
- SCAN:
  - Prescaler counts 0..SCAN_DIV-1.
  - At terminal count: prescaler <= 0, cur_idx <= cur_idx+1 mod OUT_W, D <= onehot of the new index.
  - When the step goes OUT_W-1 -> 0, wrap = 1 for exactly that cycle; otherwise wrap = 0.
  - SCAN_DIV = 1 steps every cycle.
  - sel_valid is ignored (sel_ready = 0).
- Entering SCAN from DIRECT or IDLE:
  - prescaler cleared; cur_idx keeps its value.
  - D is driven to onehot(cur_idx) on the entry edge.
  - The first step occurs SCAN_DIV cycles after entry.
- Entering DIRECT from SCAN: D and cur_idx freeze at their current values until the next handshake.
- IDLE:
  - D = all inactive, cur_idx holds, prescaler holds at 0, wrap = 0.
  - Leaving IDLE restores D = onehot(cur_idx).
- Simultaneous events:
  - mode toggling in the same cycle as sel_valid: the handshake uses the current state's sel_ready. A DIRECT-state handshake completes even as the FSM moves to SCAN; the SCAN entry then uses the newly captured index.
  - en falling in the same cycle as a handshake: the handshake is not taken, because sel_ready is computed with en.
- Width rules:
  - cur_idx + 1 is computed in SEL_W bits, so wrap-around is natural.
  - The prescaler is $clog2(SCAN_DIV+1) bits wide; for SCAN_DIV = 1 its width is forced to 1.
- Invariant: outside IDLE and reset, D always has exactly one active bit.

Decomposition:
- Shared package scan_dec_pkg holds:
  - state encoding enum (IDLE = 2'd0, DIRECT = 2'd1, SCAN = 2'd2);
  - MODE_DIRECT / MODE_SCAN constants.
- Sub-module onehot_dec:
  - parametrised, purely combinational SEL_W -> 2^SEL_W decoder;
  - instanced once; the generalisation of the existing 3x8 decoder.
- The top level holds the FSM, prescaler, index register, polarity inversion and output register.

Test Plan:
- Reset and polarity:
  - Defaults, rst_n = 0 for 2 cycles, then en = 1, mode = 0 -> D = 8'h00, cur_idx = 0, wrap = 0, sel_ready = 1 one cycle after release.
  - ACTIVE_LOW = 1 -> D = 8'hFF during reset.
- Direct decode sweep:
  - sel = 0..7 back-to-back with sel_valid = 1 -> D = 8'h01, 8'h02 .. 8'h80, each one cycle after its handshake; cur_idx tracks sel.
- Scan rate and wrap:
  - mode = 1, SCAN_DIV = 4, starting at cur_idx = 6 -> D = 8'h40 for 4 cycles, then 8'h80 for 4 cycles, then 8'h01 with wrap = 1 for one cycle.
  - Repeat with SCAN_DIV = 1 -> a step every cycle.
- Mode switch with handshake:
  - In DIRECT, sel = 5 with sel_valid = 1 and mode -> 1 in the same cycle -> D = 8'h20, then stepping to 8'h40 after 4 cycles.
  - During SCAN, sel_valid = 1 -> sel_ready = 0 and D is unaffected.
- Enable gating:
  - en = 0 mid-scan at cur_idx = 3 -> D = 8'h00 and cur_idx stays 3.
  - en = 1 again -> D = 8'h08, first step 4 cycles later.
- Reset mid-scan and width:
  - rst_n = 0 while cur_idx = 6 -> next cycle cur_idx = 0, D = 0, state IDLE.
  - SEL_W = 4 instance: sel = 15 -> D = 16'h8000.

Source files
------------

// File: rtl/scan_dec_pkg.sv
// Shared definitions for the scan decoder: FSM state encoding and mode input values.
package scan_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// Purely combinational SEL_W -> 2**SEL_W one-hot decoder.
// This is the generalisation of the old fixed 3x8 gate-level decoder.
module onehot_dec #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]      sel_i,
    output logic [2**SEL_W-1:0]   onehot_o
);

    // Set exactly the selected bit.
    always_comb begin
        onehot_o        = {(2**SEL_W){1'b0}};
        onehot_o[sel_i] = 1'b1;
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with a handshaked direct mode and a self-stepping scan mode.
// Holds the mode FSM, scan prescaler, index register and polarity-adjusted output register.
module scan_decoder
    import scan_dec_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int SCAN_DIV   = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 sel_valid,
    input  logic [SEL_W-1:0]     sel,
    output logic                 sel_ready,
    output logic [2**SEL_W-1:0]  D,
    output logic [SEL_W-1:0]     cur_idx,
    output logic                 wrap
);

    localparam int OUT_W = 2**SEL_W;
    localparam int PRE_W = (SCAN_DIV <= 1) ? 1 : $clog2(SCAN_DIV + 1);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);
    localparam logic [SEL_W-1:0] IDX_ONE  = SEL_W'(1);
    localparam logic [SEL_W-1:0] IDX_ZERO = {SEL_W{1'b0}};
    // XOR mask: all ones inverts the decode for active-low loads.
    localparam logic [OUT_W-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [OUT_W-1:0]   d_q, d_d;
    logic               wrap_q, wrap_d;

    logic               handshake_s;
    logic               scan_hold_s;
    logic               step_s;
    logic [OUT_W-1:0]   onehot_s;

    // Next-state logic: disable wins, otherwise mode picks DIRECT or SCAN.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
                ST_DIRECT: state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
                ST_SCAN:   state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    assign sel_ready   = en && (state_q == ST_DIRECT);
    assign handshake_s = sel_valid && sel_ready;
    // Stepping only happens while staying in SCAN; leaving SCAN freezes the index.
    assign scan_hold_s = (state_q == ST_SCAN) && (state_d == ST_SCAN);
    assign step_s      = scan_hold_s && (pre_q == PRE_LAST);

    // Index, prescaler and wrap update.
    always_comb begin
        idx_d  = idx_q;
        pre_d  = PRE_ZERO;
        wrap_d = 1'b0;
        if (handshake_s) begin
            idx_d = sel;
        end else if (step_s) begin
            idx_d  = idx_q + IDX_ONE;
            wrap_d = (idx_q == IDX_LAST);
        end else begin
            idx_d = idx_q;
        end
        if (scan_hold_s && !step_s) begin
            pre_d = pre_q + PRE_ONE;
        end else begin
            pre_d = PRE_ZERO;
        end
    end

    onehot_dec #(
        .SEL_W    (SEL_W)
    ) u_dec (
        .sel_i    (idx_d),
        .onehot_o (onehot_s)
    );

    // Output pattern: inactive in IDLE, otherwise decode of the next index.
    always_comb begin
        if (state_d == ST_IDLE) begin
            d_d = INACTIVE;
        end else begin
            d_d = onehot_s ^ INACTIVE;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= IDX_ZERO;
            pre_q   <= PRE_ZERO;
            wrap_q  <= 1'b0;
            d_q     <= INACTIVE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pre_q   <= pre_d;
            wrap_q  <= wrap_d;
            d_q     <= d_d;
        end
    end

    assign D       = d_q;
    assign cur_idx = idx_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench: four decoder variants share one stimulus stream and are
// compared every cycle against a cycle-counting behavioural model.
module tb_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic        sel_valid;
    logic [3:0]  sel;

    logic [7:0]  d0, d1, d2;
    logic [15:0] d3;
    logic [2:0]  idx0, idx1, idx2;
    logic [3:0]  idx3;
    logic [3:0]  wr_s;
    logic [3:0]  rdy_s;

    logic [15:0] dut_d   [4];
    logic [3:0]  dut_idx [4];

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    // Model: per instance state (0 idle, 1 direct, 2 scan), index, cycles at index, wrap.
    int m_st   [4];
    int m_idx  [4];
    int m_cnt  [4];
    int m_wrap [4];
    int p_div  [4] = '{4, 4, 1, 3};
    int p_al   [4] = '{0, 1, 0, 0};
    int p_outw [4] = '{8, 8, 8, 16};

    scan_decoder #(.SEL_W(3), .SCAN_DIV(4), .ACTIVE_LOW(0)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid),
        .sel(sel[2:0]), .sel_ready(rdy_s[0]), .D(d0), .cur_idx(idx0), .wrap(wr_s[0]));
    scan_decoder #(.SEL_W(3), .SCAN_DIV(4), .ACTIVE_LOW(1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid),
        .sel(sel[2:0]), .sel_ready(rdy_s[1]), .D(d1), .cur_idx(idx1), .wrap(wr_s[1]));
    scan_decoder #(.SEL_W(3), .SCAN_DIV(1), .ACTIVE_LOW(0)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid),
        .sel(sel[2:0]), .sel_ready(rdy_s[2]), .D(d2), .cur_idx(idx2), .wrap(wr_s[2]));
    scan_decoder #(.SEL_W(4), .SCAN_DIV(3), .ACTIVE_LOW(0)) u3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid),
        .sel(sel), .sel_ready(rdy_s[3]), .D(d3), .cur_idx(idx3), .wrap(wr_s[3]));

    assign dut_d[0]   = {8'h00, d0};
    assign dut_d[1]   = {8'h00, d1};
    assign dut_d[2]   = {8'h00, d2};
    assign dut_d[3]   = d3;
    assign dut_idx[0] = {1'b0, idx0};
    assign dut_idx[1] = {1'b0, idx1};
    assign dut_idx[2] = {1'b0, idx2};
    assign dut_idx[3] = idx3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_d(input int k);
        logic [15:0] v;
        v = (m_st[k] == 0) ? 16'h0000 : (16'h0001 << m_idx[k]);
        if (p_al[k] != 0) v = ~v & ((p_outw[k] == 16) ? 16'hFFFF : 16'h00FF);
        return v;
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_update();
        for (int k = 0; k < 4; k++) begin
            int  nst;
            bit  hs;
            bit  stay_scan;
            if (!rst_n) begin
                m_st[k] = 0; m_idx[k] = 0; m_cnt[k] = 0; m_wrap[k] = 0;
            end else begin
                hs        = sel_valid && en && (m_st[k] == 1);
                nst       = !en ? 0 : (mode ? 2 : 1);
                stay_scan = (m_st[k] == 2) && (nst == 2);
                m_wrap[k] = 0;
                if (hs) begin
                    m_idx[k] = int'(sel) % p_outw[k];
                end else if (stay_scan) begin
                    m_cnt[k]++;
                    if (m_cnt[k] == p_div[k]) begin
                        m_cnt[k]  = 0;
                        m_idx[k]  = (m_idx[k] + 1) % p_outw[k];
                        m_wrap[k] = (m_idx[k] == 0) ? 1 : 0;
                    end
                end
                if (!stay_scan) m_cnt[k] = 0;
                m_st[k] = nst;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #2;
    endtask

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("D[%0d]", k), 32'(dut_d[k]), 32'(exp_d(k)));
                chk($sformatf("cur_idx[%0d]", k), 32'(dut_idx[k]), 32'(m_idx[k]));
                chk($sformatf("wrap[%0d]", k), 32'(wr_s[k]), 32'(m_wrap[k]));
                chk($sformatf("sel_ready[%0d]", k), 32'(rdy_s[k]),
                    32'((en && m_st[k] == 1) ? 1 : 0));
            end
        end
    end

    initial begin
        logic [7:0] one8;
        logic [7:0] e8;
        one8 = 8'h01;
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel = 4'd0;

        // Reset and polarity
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_D", 32'(d0), 32'h00);
        chk("rst_idx", 32'(idx0), 32'd0);
        chk("rst_wrap", 32'(wr_s[0]), 32'd0);
        chk("rst_D_active_low", 32'(d1), 32'hFF);
        rst_n = 1'b1; en = 1'b1; mode = 1'b0;
        tick();
        chk("ready_after_release", 32'(rdy_s[0]), 32'd1);

        // Direct decode sweep, back-to-back handshakes
        sel_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sel = 4'(i);
            tick();
            chk("sweep_D", 32'(d0), 32'(one8 << i));
            chk("sweep_idx", 32'(idx0), 32'(i));
        end
        sel_valid = 1'b0;

        // Scan rate and wrap from index 6; selector offers during scan are ignored
        sel_valid = 1'b1; sel = 4'd6;
        tick();
        sel_valid = 1'b0; mode = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 5) begin sel_valid = 1'b1; sel = 4'd2; end
            if (c == 7) sel_valid = 1'b0;
            tick();
            e8 = (c < 4) ? 8'h40 : ((c < 8) ? 8'h80 : 8'h01);
            chk("scan_D", 32'(d0), 32'(e8));
            chk("scan_wrap", 32'(wr_s[0]), 32'((c == 8) ? 1 : 0));
            chk("scan_ready", 32'(rdy_s[0]), 32'd0);
            if (c < 4) begin
                chk("scan1_D", 32'(d2), 32'(one8 << ((6 + c) % 8)));
                chk("scan1_wrap", 32'(wr_s[2]), 32'((c == 2) ? 1 : 0));
            end
        end

        // Handshake in the same cycle as the switch to scan
        mode = 1'b0;
        tick();
        sel_valid = 1'b1; sel = 4'd5; mode = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            sel_valid = 1'b0;
            chk("switch_D", 32'(d0), 32'((c < 4) ? 8'h20 : 8'h40));
        end

        // Enable gating mid-scan at index 3
        mode = 1'b0;
        tick();
        sel_valid = 1'b1; sel = 4'd3; mode = 1'b1;
        tick();
        sel_valid = 1'b0;
        tick();
        tick();
        en = 1'b0;
        tick();
        chk("gate_D", 32'(d0), 32'h00);
        chk("gate_idx", 32'(idx0), 32'd3);
        chk("gate_D_active_low", 32'(d1), 32'hFF);
        tick();
        chk("gate_idx_hold", 32'(idx0), 32'd3);
        en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("regate_D", 32'(d0), 32'((c < 4) ? 8'h08 : 8'h10));
        end

        // Reset mid-scan at index 6
        mode = 1'b0;
        tick();
        sel_valid = 1'b1; sel = 4'd6; mode = 1'b1;
        tick();
        sel_valid = 1'b0;
        tick();
        chk("pre_reset_idx", 32'(idx0), 32'd6);
        rst_n = 1'b0;
        tick();
        chk("midreset_idx", 32'(idx0), 32'd0);
        chk("midreset_D", 32'(d0), 32'h00);
        chk("midreset_ready", 32'(rdy_s[0]), 32'd0);
        rst_n = 1'b1;

        // Wider instance
        mode = 1'b0;
        tick();
        sel_valid = 1'b1; sel = 4'd15;
        tick();
        sel_valid = 1'b0;
        chk("w4_D", 32'(d3), 32'h8000);
        chk("w4_idx", 32'(idx3), 32'd15);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 63) != 0);
            en        = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 31) == 0) mode = ~mode;
            sel_valid = 1'($urandom_range(0, 1));
            sel       = 4'($urandom_range(0, 15));
            tick();
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
